// File: rtl/button_conditioner_pkg.sv
// Shared types and default sizing for the push-button conditioner.
package btn_cond_pkg;

  localparam int DEF_N = 18;  // debounce counter width, window = 2^N clocks
  localparam int DEF_W = 3;   // number of button channels

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_e;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw levels in, debounced levels and edge ticks out.
interface button_conditioner_if #(
  parameter int W = btn_cond_pkg::DEF_W
);
  logic [W-1:0] btn;
  logic [W-1:0] db_level;
  logic [W-1:0] rise_tick;
  logic [W-1:0] fall_tick;

  modport master (output btn, input db_level, rise_tick, fall_tick);
  modport slave  (input btn, output db_level, rise_tick, fall_tick);
endinterface

// File: rtl/button_conditioner_debounce_fsm.sv
// Single debounce channel: 2-flop synchronizer, stability counter,
// level FSM and registered edge ticks.
//
// state | meaning
// ------+-------------------------------------------------------------
// ZERO  | debounced low, input low
// WAIT1 | debounced low, input high, counting toward a confirmed press
// ONE   | debounced high, input high
// WAIT0 | debounced high, input low, counting toward a confirmed release
module debounce_fsm
  import btn_cond_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic         s1, s2;
  db_state_e    state, state_nxt;
  logic [N-1:0] cnt, cnt_nxt;
  logic         rise_nxt, fall_nxt;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // State, counter and tick registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ZERO;
      cnt       <= '0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rise_tick <= rise_nxt;
      fall_tick <= fall_nxt;
    end
  end

  // Next-state logic; the counter stops at terminal count because the FSM leaves the wait state there.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      ZERO: begin
        if (s2) begin
          state_nxt = WAIT1;
          cnt_nxt   = '0;
        end
      end
      WAIT1: begin
        if (!s2) begin
          state_nxt = ZERO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ONE;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ONE: begin
        if (!s2) begin
          state_nxt = WAIT0;
          cnt_nxt   = '0;
        end
      end
      WAIT0: begin
        if (s2) begin
          state_nxt = ONE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ZERO;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ZERO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Level is a pure decode of the registered state.
  assign db_level = (state == ONE) || (state == WAIT0);

endmodule

// File: rtl/button_conditioner.sv
// W independent debounced button channels with rise/fall ticks.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  button_conditioner_if.slave  bus
);

  logic [W-1:0] db_level_w;
  logic [W-1:0] rise_tick_w;
  logic [W-1:0] fall_tick_w;

  for (genvar i = 0; i < W; i++) begin : g_ch
    debounce_fsm #(.N(N)) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn       (bus.btn[i]),
      .db_level  (db_level_w[i]),
      .rise_tick (rise_tick_w[i]),
      .fall_tick (fall_tick_w[i])
    );
  end

  assign bus.db_level  = db_level_w;
  assign bus.rise_tick = rise_tick_w;
  assign bus.fall_tick = fall_tick_w;

endmodule
